block_memory: RTL and testbench

- Main-memory backing store that sits directly downstream of the 2-way write-through data cache.
- Serves whole 16-byte blocks over a 128-bit bus: block fills on cache misses and block write-throughs/write-backs from the cache.
- Replaces the zero-latency behavioural memory with a clocked, multi-cycle, handshaked model so cache stall logic can be exercised.
- Capacity is 1 KiB: 64 blocks × 16 bytes, byte-addressed by a 10-bit address.

---
 rtl/block_memory.sv | 130 +++++++++++++
 tb/tb_block_memory.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/block_memory.sv
// Clocked 64 x 128-bit block store with req/ready/done handshake and fixed access latency.
// Optional MEM_STATS_EN adds saturating read/write commit counters (rd_count, wr_count).
module block_memory #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              read_write,
    input  logic [ADDR_W-1:0] memaddr,
    input  logic [127:0]      memwrite,
    output logic [127:0]      memread,
`ifdef MEM_STATS_EN
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
`endif
    output logic              ready,
    output logic              done
);

    localparam int IDX_W = ADDR_W - 4;
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             rw_q, rw_d;
    logic [127:0]     wdata_q, wdata_d;
    logic [127:0]     memread_q, memread_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             commit;

    logic [127:0] mem [DEPTH];

    // Low address bits select a byte inside the block and are irrelevant here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^memaddr[3:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rw_d      = rw_q;
        wdata_d   = wdata_q;
        memread_d = memread_q;
        commit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d   = memaddr[ADDR_W-1:4];
                    rw_d    = read_write;
                    wdata_d = memwrite;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    commit  = 1'b1;
                    if (!rw_q) memread_d = mem[idx_q];
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            memread_q <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            memread_q <= memread_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
        idx_q   <= idx_d;
        rw_q    <= rw_d;
        wdata_q <= wdata_d;
    end

    // A reset coinciding with the commit edge aborts the write.
    always_ff @(posedge clk) begin
        if (!rst && commit && rw_q) mem[idx_q] <= wdata_q;
    end

`ifdef MEM_STATS_EN
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;

    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (commit && !rw_q && rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
        if (commit &&  rw_q && wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_q <= 16'd0;
            wr_count_q <= 16'd0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

    assign memread = memread_q;
    assign ready   = ready_q;
    assign done    = done_q;

endmodule

// File: tb/tb_block_memory.sv
// Self-checking bench for block_memory against an array-based reference of the block store.
// Define MEM_STATS_EN to also exercise the commit counters.
module tb_block_memory;

    localparam int ADDR_W  = 10;
    localparam int LATENCY = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req = 1'b0;
    logic         read_write = 1'b0;
    logic [9:0]   memaddr = '0;
    logic [127:0] memwrite = '0;
    logic [127:0] memread;
    logic         ready;
    logic         done;
`ifdef MEM_STATS_EN
    logic [15:0]  rd_count;
    logic [15:0]  wr_count;
`endif

    int checks = 0;
    int failures = 0;

    logic [127:0] ref_mem [64];
    bit           ref_valid [64];
    logic [127:0] ref_memread;
    int           exp_rd = 0;
    int           exp_wr = 0;

    block_memory #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst), .req(req), .read_write(read_write),
        .memaddr(memaddr), .memwrite(memwrite), .memread(memread),
`ifdef MEM_STATS_EN
        .rd_count(rd_count), .wr_count(wr_count),
`endif
        .ready(ready), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for ready, issues one access, returns edges from accept to done (99 on timeout).
    task automatic access(input bit rw, input logic [9:0] a, input logic [127:0] d,
                          output int lat);
        int n = 0;
        while (!ready && n < 50) begin tick(); n++; end
        req = 1'b1; read_write = rw; memaddr = a; memwrite = d;
        tick();
        req = 1'b0; read_write = 1'b0; memaddr = $urandom; memwrite = {4{$urandom}};
        lat = 0;
        while (!done && lat < 40) begin tick(); lat++; end
        if (!done) lat = 99;
        if (lat != 99) begin
            if (rw) begin
                ref_mem[a[9:4]] = d; ref_valid[a[9:4]] = 1'b1; exp_wr++;
            end else begin
                ref_memread = ref_mem[a[9:4]]; exp_rd++;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 1'b0;
        tick(); tick();
        rst = 1'b0;
        ref_memread = '0; exp_rd = 0; exp_wr = 0;
    endtask

    task automatic test_reset();
        int pulses = 0;
        do_reset();
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", ready); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (memread !== 128'h0) begin failures++; $display("FAIL reset_memread got=%h want=0", memread); end
        for (int i = 0; i < 10; i++) begin tick(); if (done) pulses++; end
        checks++; if (pulses != 0) begin failures++; $display("FAIL idle_no_done got=%0d pulses want=0", pulses); end
    endtask

    task automatic test_write_read();
        int lat;
        logic [127:0] p = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        access(1'b1, 10'h1A5, p, lat);
        checks++; if (lat != LATENCY) begin failures++; $display("FAIL wr_latency got=%0d want=%0d", lat, LATENCY); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL ready_in_done got=%b want=0", ready); end
        access(1'b0, 10'h1A0, 128'h0, lat);
        checks++; if (lat != LATENCY) begin failures++; $display("FAIL rd_latency got=%0d want=%0d", lat, LATENCY); end
        checks++; if (memread !== p) begin failures++; $display("FAIL rd_data got=%h want=%h", memread, p); end
        checks++; if (memread[127:120] !== 8'h00 || memread[7:0] !== 8'hFF) begin
            failures++; $display("FAIL byte_order got=%h/%h want=00/ff", memread[127:120], memread[7:0]);
        end
    endtask

    task automatic test_busy_drop();
        int lat = 0;
        int pulses = 0;
        logic [127:0] p = {$urandom, $urandom, $urandom, $urandom};
        // Start a write, then hammer an all-ones write request while busy.
        while (!ready && lat < 50) begin tick(); lat++; end
        req = 1'b1; read_write = 1'b1; memaddr = 10'h040; memwrite = p;
        tick();
        memwrite = '1;
        lat = 0;
        while (!done && lat < 40) begin tick(); lat++; end
        req = 1'b0;
        checks++; if (lat != LATENCY) begin failures++; $display("FAIL drop_latency got=%0d want=%0d", lat, LATENCY); end
        ref_mem[4] = p; ref_valid[4] = 1'b1; exp_wr++;
        for (int i = 0; i < 10; i++) begin tick(); if (done) pulses++; end
        checks++; if (pulses != 0) begin failures++; $display("FAIL drop_extra_done got=%0d want=0", pulses); end
        access(1'b0, 10'h040, 128'h0, lat);
        checks++; if (memread !== p) begin failures++; $display("FAIL drop_data got=%h want=%h", memread, p); end
    endtask

    task automatic test_wrap();
        int lat;
        logic [127:0] p0 = {$urandom, $urandom, $urandom, $urandom};
        logic [127:0] p63 = ~p0;
        access(1'b1, 10'h000, p0, lat);
        access(1'b1, 10'h3FF, p63, lat);
        access(1'b0, 10'h00C, 128'h0, lat);
        checks++; if (memread !== p0) begin failures++; $display("FAIL blk0 got=%h want=%h", memread, p0); end
        access(1'b1, 10'h005, {4{$urandom}}, lat);
        checks++; if (memread !== p0) begin failures++; $display("FAIL memread_held got=%h want=%h", memread, p0); end
        access(1'b0, 10'h3F0, 128'h0, lat);
        checks++; if (memread !== p63) begin failures++; $display("FAIL blk63 got=%h want=%h", memread, p63); end
    endtask

    task automatic test_reset_mid_op();
        int lat = 0;
        logic [127:0] old = ref_mem[63];
        while (!ready && lat < 50) begin tick(); lat++; end
        req = 1'b1; read_write = 1'b1; memaddr = 10'h3F0; memwrite = ~old;
        tick();
        req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ref_memread = '0; exp_rd = 0; exp_wr = 0;
        checks++; if (ready !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL midrst_ctrl got=ready%b done%b want=ready1 done0", ready, done);
        end
        checks++; if (memread !== 128'h0) begin failures++; $display("FAIL midrst_memread got=%h want=0", memread); end
        access(1'b0, 10'h3F0, 128'h0, lat);
        checks++; if (memread !== old) begin failures++; $display("FAIL midrst_old got=%h want=%h", memread, old); end
    endtask

    task automatic test_back_to_back();
        int lat;
        int gap;
        logic [127:0] p = {$urandom, $urandom, $urandom, $urandom};
        access(1'b1, 10'h2B7, p, lat);
        gap = 0;
        while (!ready && gap < 10) begin tick(); gap++; end
        checks++; if (gap != 1) begin failures++; $display("FAIL ready_return got=%0d edges want=1", gap); end
        access(1'b0, 10'h2B0, 128'h0, lat);
        checks++; if (memread !== p) begin failures++; $display("FAIL b2b_data got=%h want=%h", memread, p); end
    endtask

    task automatic test_random();
        int lat;
        int bad = 0;
        for (int i = 0; i < 40; i++) begin
            logic [9:0] a = 10'($urandom);
            logic [127:0] d = {$urandom, $urandom, $urandom, $urandom};
            bit rw = ($urandom_range(0, 1) == 1) || !ref_valid[a[9:4]];
            access(rw, a, d, lat);
            checks++;
            if (lat != LATENCY || memread !== ref_memread) begin
                failures++; bad++;
                if (bad < 5) $display("FAIL rand_%0d got=%h lat=%0d want=%h lat=%0d", i, memread, lat, ref_memread, LATENCY);
            end
        end
    endtask

`ifdef MEM_STATS_EN
    task automatic test_stats();
        int lat;
        do_reset();
        checks++; if (rd_count !== 16'd0 || wr_count !== 16'd0) begin
            failures++; $display("FAIL stats_reset got=%0d/%0d want=0/0", rd_count, wr_count);
        end
        access(1'b1, 10'h100, {4{$urandom}}, lat);
        access(1'b1, 10'h110, {4{$urandom}}, lat);
        access(1'b0, 10'h100, 128'h0, lat);
        access(1'b0, 10'h110, 128'h0, lat);
        // Third read with a dropped write request held during its busy window.
        while (!ready) tick();
        req = 1'b1; read_write = 1'b0; memaddr = 10'h100;
        tick();
        read_write = 1'b1;
        lat = 0;
        while (!done && lat < 40) begin tick(); lat++; end
        req = 1'b0; exp_rd++;
        tick(); tick(); tick();
        checks++; if (rd_count !== 16'(exp_rd) || wr_count !== 16'(exp_wr)) begin
            failures++; $display("FAIL stats_count got=%0d/%0d want=%0d/%0d", rd_count, wr_count, exp_rd, exp_wr);
        end
        do_reset();
        checks++; if (rd_count !== 16'd0 || wr_count !== 16'd0) begin
            failures++; $display("FAIL stats_clear got=%0d/%0d want=0/0", rd_count, wr_count);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 64; i++) begin ref_valid[i] = 1'b0; ref_mem[i] = '0; end
        ref_memread = '0;
        test_reset();
        test_write_read();
        test_busy_drop();
        test_wrap();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
`ifdef MEM_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
